bsg_manycore_ruche_x_link_repeater: RTL and testbench

//  Elastic pipeline stage on the horizontal ruche link between two compute tiles whose ruche ports are too far apart for one cycle.

---
 rtl/bsg_manycore_ruche_x_link_repeater.sv | 212 +++++++++++++++++++++
 tb/tb_bsg_manycore_ruche_x_link_repeater.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/bsg_manycore_ruche_x_link_repeater.sv
// Registered elastic repeater for the horizontal ruche link: four independent els_p-deep FIFOs.
// Optional per-channel packet/stall counters on stat_o when BSG_MANYCORE_RUCHE_REPEATER_STATS_EN is defined.

module bsg_manycore_ruche_x_link_repeater_fifo #(
    parameter int unsigned width_p = 8,
    parameter int unsigned els_p   = 2
) (
    input  logic               clk_i,
    input  logic               reset_n_i,
    input  logic               v_i,
    input  logic [width_p-1:0] data_i,
    output logic               ready_o,
    output logic               v_o,
    output logic [width_p-1:0] data_o,
    input  logic               ready_i
);
    localparam int unsigned ptr_w = $clog2(els_p);
    localparam int unsigned cnt_w = $clog2(els_p + 1);
    localparam logic [ptr_w-1:0] last_ptr = ptr_w'(els_p - 1);
    localparam logic [cnt_w-1:0] full_cnt = cnt_w'(els_p);

    logic [width_p-1:0] mem_q [els_p];
    logic [ptr_w-1:0]   rd_ptr_q, rd_ptr_d;
    logic [ptr_w-1:0]   wr_ptr_q, wr_ptr_d;
    logic [ptr_w-1:0]   prev_rd_ptr;
    logic [cnt_w-1:0]   cnt_q, cnt_d;
    logic               ready_en_q;
    logic               enq;
    logic               deq;

    // Ready comes only from registered state, never from the downstream ready.
    assign ready_o = ready_en_q & (cnt_q != full_cnt);
    assign v_o     = (cnt_q != '0);
    assign enq     = v_i & ready_o;
    assign deq     = v_o & ready_i;

    // When empty, keep presenting the most recently dequeued entry.
    assign prev_rd_ptr = (rd_ptr_q == '0) ? last_ptr : rd_ptr_q - ptr_w'(1);
    assign data_o      = v_o ? mem_q[rd_ptr_q] : mem_q[prev_rd_ptr];

    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        cnt_d    = cnt_q;
        if (enq) begin
            wr_ptr_d = (wr_ptr_q == last_ptr) ? '0 : wr_ptr_q + ptr_w'(1);
        end
        if (deq) begin
            rd_ptr_d = (rd_ptr_q == last_ptr) ? '0 : rd_ptr_q + ptr_w'(1);
        end
        if (enq & ~deq) begin
            cnt_d = cnt_q + cnt_w'(1);
        end else if (deq & ~enq) begin
            cnt_d = cnt_q - cnt_w'(1);
        end
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            cnt_q      <= '0;
            ready_en_q <= 1'b0;
        end else begin
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            cnt_q      <= cnt_d;
            ready_en_q <= 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (enq) begin
            mem_q[wr_ptr_q] <= data_i;
        end
    end
endmodule

module bsg_manycore_ruche_x_link_repeater #(
    parameter int unsigned addr_width_p   = 10,
    parameter int unsigned data_width_p   = 32,
    parameter int unsigned x_cord_width_p = 4,
    parameter int unsigned y_cord_width_p = 3,
    parameter int unsigned els_p          = 2,
    localparam int unsigned fwd_pkt_width_lp = addr_width_p + data_width_p + data_width_p / 8 + 5 + 2
                                             + 2 * (x_cord_width_p + y_cord_width_p),
    localparam int unsigned rev_pkt_width_lp = 2 + data_width_p + 5 + x_cord_width_p + y_cord_width_p,
    localparam int unsigned ruche_x_link_sif_width_lp = fwd_pkt_width_lp + rev_pkt_width_lp + 4
) (
    input  logic                                 clk_i,
    input  logic                                 reset_n_i,
    input  logic [ruche_x_link_sif_width_lp-1:0] a_link_i,
    output logic [ruche_x_link_sif_width_lp-1:0] a_link_o,
    input  logic [ruche_x_link_sif_width_lp-1:0] b_link_i,
    output logic [ruche_x_link_sif_width_lp-1:0] b_link_o
`ifdef BSG_MANYCORE_RUCHE_REPEATER_STATS_EN
  , output logic [3:0][1:0][31:0]                stat_o
`endif
);
    localparam int unsigned fw_lp = fwd_pkt_width_lp;
    localparam int unsigned rw_lp = rev_pkt_width_lp;

    // Link sif layout, MSB first: {fwd.v, fwd.data, fwd.ready_and_rev, rev.v, rev.data, rev.ready_and_rev}.
    localparam int unsigned rev_rdy_bit_lp  = 0;
    localparam int unsigned rev_data_lsb_lp = 1;
    localparam int unsigned rev_v_bit_lp    = rw_lp + 1;
    localparam int unsigned fwd_rdy_bit_lp  = rw_lp + 2;
    localparam int unsigned fwd_data_lsb_lp = rw_lp + 3;
    localparam int unsigned fwd_v_bit_lp    = rw_lp + 3 + fw_lp;

    logic             f_ab_v, f_ab_ready;
    logic             r_ab_v, r_ab_ready;
    logic             f_ba_v, f_ba_ready;
    logic             r_ba_v, r_ba_ready;
    logic [fw_lp-1:0] f_ab_data, f_ba_data;
    logic [rw_lp-1:0] r_ab_data, r_ba_data;

    bsg_manycore_ruche_x_link_repeater_fifo #(.width_p(fw_lp), .els_p(els_p)) u_f_ab (
        .clk_i    (clk_i),
        .reset_n_i(reset_n_i),
        .v_i      (a_link_i[fwd_v_bit_lp]),
        .data_i   (a_link_i[fwd_data_lsb_lp +: fw_lp]),
        .ready_o  (f_ab_ready),
        .v_o      (f_ab_v),
        .data_o   (f_ab_data),
        .ready_i  (b_link_i[fwd_rdy_bit_lp])
    );

    bsg_manycore_ruche_x_link_repeater_fifo #(.width_p(rw_lp), .els_p(els_p)) u_r_ab (
        .clk_i    (clk_i),
        .reset_n_i(reset_n_i),
        .v_i      (a_link_i[rev_v_bit_lp]),
        .data_i   (a_link_i[rev_data_lsb_lp +: rw_lp]),
        .ready_o  (r_ab_ready),
        .v_o      (r_ab_v),
        .data_o   (r_ab_data),
        .ready_i  (b_link_i[rev_rdy_bit_lp])
    );

    bsg_manycore_ruche_x_link_repeater_fifo #(.width_p(fw_lp), .els_p(els_p)) u_f_ba (
        .clk_i    (clk_i),
        .reset_n_i(reset_n_i),
        .v_i      (b_link_i[fwd_v_bit_lp]),
        .data_i   (b_link_i[fwd_data_lsb_lp +: fw_lp]),
        .ready_o  (f_ba_ready),
        .v_o      (f_ba_v),
        .data_o   (f_ba_data),
        .ready_i  (a_link_i[fwd_rdy_bit_lp])
    );

    bsg_manycore_ruche_x_link_repeater_fifo #(.width_p(rw_lp), .els_p(els_p)) u_r_ba (
        .clk_i    (clk_i),
        .reset_n_i(reset_n_i),
        .v_i      (b_link_i[rev_v_bit_lp]),
        .data_i   (b_link_i[rev_data_lsb_lp +: rw_lp]),
        .ready_o  (r_ba_ready),
        .v_o      (r_ba_v),
        .data_o   (r_ba_data),
        .ready_i  (a_link_i[rev_rdy_bit_lp])
    );

    assign a_link_o = {f_ba_v, f_ba_data, f_ab_ready, r_ba_v, r_ba_data, r_ab_ready};
    assign b_link_o = {f_ab_v, f_ab_data, f_ba_ready, r_ab_v, r_ab_data, r_ba_ready};

`ifdef BSG_MANYCORE_RUCHE_REPEATER_STATS_EN
    // Channel order: 0=f_ab, 1=r_ab, 2=f_ba, 3=r_ba.
    logic [3:0]  ch_v;
    logic [3:0]  ch_ready;
    logic [31:0] pkt_cnt_q   [4];
    logic [31:0] pkt_cnt_d   [4];
    logic [31:0] stall_cnt_q [4];
    logic [31:0] stall_cnt_d [4];

    assign ch_v     = {r_ba_v, f_ba_v, r_ab_v, f_ab_v};
    assign ch_ready = {a_link_i[rev_rdy_bit_lp], a_link_i[fwd_rdy_bit_lp],
                       b_link_i[rev_rdy_bit_lp], b_link_i[fwd_rdy_bit_lp]};

    // Saturating counters: packets dequeued and cycles stalled by the sink.
    always_comb begin
        for (int i = 0; i < 4; i++) begin
            pkt_cnt_d[i]   = pkt_cnt_q[i];
            stall_cnt_d[i] = stall_cnt_q[i];
            if (ch_v[i] & ch_ready[i] & (pkt_cnt_q[i] != 32'hFFFF_FFFF)) begin
                pkt_cnt_d[i] = pkt_cnt_q[i] + 32'd1;
            end
            if (ch_v[i] & ~ch_ready[i] & (stall_cnt_q[i] != 32'hFFFF_FFFF)) begin
                stall_cnt_d[i] = stall_cnt_q[i] + 32'd1;
            end
        end
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            for (int i = 0; i < 4; i++) begin
                pkt_cnt_q[i]   <= '0;
                stall_cnt_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < 4; i++) begin
                pkt_cnt_q[i]   <= pkt_cnt_d[i];
                stall_cnt_q[i] <= stall_cnt_d[i];
            end
        end
    end

    always_comb begin
        for (int i = 0; i < 4; i++) begin
            stat_o[i] = {pkt_cnt_q[i], stall_cnt_q[i]};
        end
    end
`endif
endmodule

// File: tb/tb_bsg_manycore_ruche_x_link_repeater.sv
// Bench for the ruche x-link repeater: per-channel queue model checked every cycle plus directed literal checks.
`timescale 1ns/1ps

module tb_bsg_manycore_ruche_x_link_repeater;
    localparam int unsigned AW  = 10;
    localparam int unsigned DW  = 32;
    localparam int unsigned XW  = 4;
    localparam int unsigned YW  = 3;
    localparam int unsigned ELS = 2;
    localparam int unsigned FW  = AW + DW + DW / 8 + 5 + 2 + 2 * (XW + YW);
    localparam int unsigned RVW = 2 + DW + 5 + XW + YW;
    localparam int unsigned RW  = FW + RVW + 4;

    logic          clk_i = 1'b0;
    logic          reset_n_i = 1'b0;
    logic [RW-1:0] a_link_i, a_link_o, b_link_i, b_link_o;

    // Channel view: 0=f_ab, 1=r_ab, 2=f_ba, 3=r_ba
    logic          in_v     [4];
    logic [FW-1:0] in_d     [4];
    logic          sink_rdy [4];
    logic          out_v    [4];
    logic [FW-1:0] out_d    [4];
    logic          up_rdy   [4];

    int errors = 0;
    int checks = 0;

    always #5 clk_i = ~clk_i;

    assign a_link_i = {in_v[0], in_d[0], sink_rdy[2], in_v[1], in_d[1][RVW-1:0], sink_rdy[3]};
    assign b_link_i = {in_v[2], in_d[2], sink_rdy[0], in_v[3], in_d[3][RVW-1:0], sink_rdy[1]};

    assign out_v[0]  = b_link_o[RVW+3+FW];
    assign out_d[0]  = b_link_o[RVW+3 +: FW];
    assign up_rdy[0] = a_link_o[RVW+2];
    assign out_v[1]  = b_link_o[RVW+1];
    assign out_d[1]  = FW'(b_link_o[1 +: RVW]);
    assign up_rdy[1] = a_link_o[0];
    assign out_v[2]  = a_link_o[RVW+3+FW];
    assign out_d[2]  = a_link_o[RVW+3 +: FW];
    assign up_rdy[2] = b_link_o[RVW+2];
    assign out_v[3]  = a_link_o[RVW+1];
    assign out_d[3]  = FW'(a_link_o[1 +: RVW]);
    assign up_rdy[3] = b_link_o[0];

`ifdef BSG_MANYCORE_RUCHE_REPEATER_STATS_EN
    logic [3:0][1:0][31:0] stat_o;
`endif

    bsg_manycore_ruche_x_link_repeater #(
        .addr_width_p  (AW),
        .data_width_p  (DW),
        .x_cord_width_p(XW),
        .y_cord_width_p(YW),
        .els_p         (ELS)
    ) dut (
        .clk_i    (clk_i),
        .reset_n_i(reset_n_i),
        .a_link_i (a_link_i),
        .a_link_o (a_link_o),
        .b_link_i (b_link_i),
        .b_link_o (b_link_o)
`ifdef BSG_MANYCORE_RUCHE_REPEATER_STATS_EN
      , .stat_o   (stat_o)
`endif
    );

    task automatic check(input string name, input logic [FW-1:0] act, input logic [FW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: each channel is a bounded queue; ready appears one edge after reset release.
    logic [FW-1:0] mq [4][$];
    bit            rdy_en;

    initial begin
        bit            p_enq [4];
        bit            p_deq [4];
        logic [FW-1:0] p_d   [4];
        rdy_en = 1'b0;
        forever begin
            @(negedge clk_i);
            for (int ch = 0; ch < 4; ch++) begin
                p_enq[ch] = 1'b0;
                p_deq[ch] = 1'b0;
                p_d[ch]   = '0;
            end
            if (!reset_n_i) begin
                for (int ch = 0; ch < 4; ch++) mq[ch].delete();
                rdy_en = 1'b0;
            end else begin
                for (int ch = 0; ch < 4; ch++) begin
                    bit ev, er;
                    ev = (mq[ch].size() != 0);
                    er = rdy_en && (mq[ch].size() < ELS);
                    check($sformatf("model_ch%0d_v", ch), FW'(out_v[ch]), FW'(ev));
                    check($sformatf("model_ch%0d_ready", ch), FW'(up_rdy[ch]), FW'(er));
                    if (ev) check($sformatf("model_ch%0d_data", ch), out_d[ch], mq[ch][0]);
                    p_deq[ch] = ev && sink_rdy[ch];
                    p_enq[ch] = er && in_v[ch];
                    p_d[ch]   = (ch % 2 == 1) ? FW'(in_d[ch][RVW-1:0]) : in_d[ch];
                end
            end
            @(posedge clk_i);
            if (reset_n_i) begin
                for (int ch = 0; ch < 4; ch++) begin
                    if (p_deq[ch]) void'(mq[ch].pop_front());
                    if (p_enq[ch]) mq[ch].push_back(p_d[ch]);
                end
                rdy_en = 1'b1;
            end
        end
    end

    // Back-to-back stream on f_ab with an always-ready sink; value base+i-1 must show every cycle.
    task automatic stream(input int n, input int base, input string nm);
        for (int i = 0; i <= n; i++) begin
            @(posedge clk_i); #1;
            in_v[0] = (i < n);
            in_d[0] = FW'(base + i);
            @(negedge clk_i);
            if (i > 0) begin
                check({nm, "_v"}, FW'(out_v[0]), FW'(1));
                check({nm, "_data"}, out_d[0], FW'(base + i - 1));
            end
        end
    endtask

    initial begin
        int acc;
        bit hs;
        for (int ch = 0; ch < 4; ch++) begin
            in_v[ch]     = 1'b1;
            in_d[ch]     = FW'(ch + 1);
            sink_rdy[ch] = 1'b1;
        end

        // Reset held with all valids high
        repeat (3) @(negedge clk_i);
        for (int ch = 0; ch < 4; ch++) begin
            check($sformatf("rst_ch%0d_v", ch), FW'(out_v[ch]), FW'(0));
            check($sformatf("rst_ch%0d_ready", ch), FW'(up_rdy[ch]), FW'(0));
        end
        @(posedge clk_i); #2;
        reset_n_i = 1'b1;
        @(posedge clk_i); #1;
        for (int ch = 0; ch < 4; ch++) begin
            check($sformatf("rel_ch%0d_ready", ch), FW'(up_rdy[ch]), FW'(1));
            check($sformatf("rel_ch%0d_v", ch), FW'(out_v[ch]), FW'(0));
            in_v[ch] = 1'b0;
        end

        stream(100, 0, "stream");

        // Backpressure: ready must drop after exactly ELS accepts
        @(posedge clk_i); #1;
        sink_rdy[0] = 1'b0;
        in_v[0]     = 1'b1;
        in_d[0]     = FW'(200);
        acc = 0;
        repeat (6) begin
            @(negedge clk_i);
            hs = up_rdy[0];
            @(posedge clk_i);
            if (hs) acc++;
            #1;
            in_d[0] = FW'(200 + acc);
        end
        in_v[0] = 1'b0;
        check("bp_accepts", FW'(acc), FW'(ELS));
        @(negedge clk_i);
        check("bp_ready_low", FW'(up_rdy[0]), FW'(0));
        @(posedge clk_i); #1;
        sink_rdy[0] = 1'b1;
        for (int k = 0; k < ELS; k++) begin
            @(negedge clk_i);
            check("bp_drain_v", FW'(out_v[0]), FW'(1));
            check("bp_drain_data", out_d[0], FW'(200 + k));
        end
        @(negedge clk_i);
        check("bp_drained_empty", FW'(out_v[0]), FW'(0));

        // Independence: r_ba saturated while f_ab streams
        @(posedge clk_i); #1;
        in_v[3]     = 1'b1;
        in_d[3]     = FW'(33);
        sink_rdy[3] = 1'b0;
        stream(20, 1000, "indep");
        @(negedge clk_i);
        check("indep_rba_full", FW'(up_rdy[3]), FW'(0));

        // Reset with two packets buffered in f_ab
        @(posedge clk_i); #1;
        in_v[3]     = 1'b0;
        sink_rdy[0] = 1'b0;
        in_v[0]     = 1'b1;
        in_d[0]     = FW'(500);
        @(posedge clk_i); #1;
        in_d[0] = FW'(501);
        @(posedge clk_i); #1;
        in_v[0] = 1'b0;
        @(negedge clk_i);
        check("mid_pre_v", FW'(out_v[0]), FW'(1));
        check("mid_pre_data", out_d[0], FW'(500));
        check("mid_pre_full", FW'(up_rdy[0]), FW'(0));
        @(posedge clk_i); #3;
        reset_n_i = 1'b0;
        #1;
        check("mid_async_v", FW'(out_v[0]), FW'(0));
        check("mid_async_ready", FW'(up_rdy[0]), FW'(0));
        check("mid_async_rba_v", FW'(out_v[3]), FW'(0));
        repeat (2) @(posedge clk_i);
        #2;
        reset_n_i   = 1'b1;
        sink_rdy[0] = 1'b1;
        sink_rdy[3] = 1'b1;
        @(posedge clk_i); #1;
        check("mid_post_ready", FW'(up_rdy[0]), FW'(1));
        check("mid_post_empty", FW'(out_v[0]), FW'(0));
        in_v[0] = 1'b1;
        in_d[0] = FW'(85);
        @(posedge clk_i); #1;
        in_v[0] = 1'b0;
        @(negedge clk_i);
        check("mid_next_v", FW'(out_v[0]), FW'(1));
        check("mid_next_data", out_d[0], FW'(85));
        @(negedge clk_i);
        check("mid_next_gone", FW'(out_v[0]), FW'(0));

`ifdef BSG_MANYCORE_RUCHE_REPEATER_STATS_EN
        @(posedge clk_i); #2;
        reset_n_i = 1'b0;
        @(posedge clk_i); #2;
        reset_n_i = 1'b1;
        @(posedge clk_i); #1;
        sink_rdy[0] = 1'b0;
        in_v[0]     = 1'b1;
        in_d[0]     = FW'(0);
        @(posedge clk_i); #1;
        in_v[0] = 1'b0;
        repeat (3) @(posedge clk_i);
        #1;
        sink_rdy[0] = 1'b1;
        stream(9, 1, "stats_stream");
        repeat (2) @(posedge clk_i);
        #1;
        check("stats_pkt", FW'(stat_o[0][1]), FW'(10));
        check("stats_stall", FW'(stat_o[0][0]), FW'(3));
        @(negedge clk_i);
        dut.pkt_cnt_q[0] = 32'hFFFF_FFFE;
        stream(3, 20, "stats_sat_stream");
        repeat (2) @(posedge clk_i);
        #1;
        check("stats_sat", FW'(stat_o[0][1]), FW'(32'hFFFF_FFFF));
        check("stats_stall_keep", FW'(stat_o[0][0]), FW'(3));
`endif

        repeat (3) @(posedge clk_i);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, errors=%0d", errors);
        $fatal(1);
    end
endmodule
